spi_flash_responder: RTL and testbench

//  Synthesizable SPI mode-0 target that emulates a small serial NOR flash.
//  It answers the APB SPI master's single-lane command stream on CSn/SCK/SDO,
//  so on-chip flash-boot and driver tests run without the vendor behavioural model.

---
 rtl/spi_flash_responder.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a small serial NOR flash. All SPI pins are oversampled in clk.
// Optional FAST_READ (0x0B) support is enabled by defining SPI_RESP_FAST_READ_EN.
module spi_flash_responder #(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [23:0] JEDEC_ID    = 24'h012018,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_csn,
  input  logic spi_si,
  output logic spi_so,
  output logic spi_so_oe,
  output logic active,
  output logic wel
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
`ifdef SPI_RESP_FAST_READ_EN
  localparam logic [7:0] OP_FAST = 8'h0B;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_IGNORE
`ifdef SPI_RESP_FAST_READ_EN
    , S_DUMMY
`endif
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, si_sync_q;
  logic                   sck_prev_q, csn_prev_q;
  logic                   sck_s, csn_s, si_s;
  logic                   sck_rise, sck_fall, csn_rise, csn_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= '0;
      csn_sync_q <= '1;
      si_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= (sck_sync_q << 1) | SYNC_STAGES'(spi_clk);
      csn_sync_q <= (csn_sync_q << 1) | SYNC_STAGES'(spi_csn);
      si_sync_q  <= (si_sync_q << 1) | SYNC_STAGES'(spi_si);
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign si_s     = si_sync_q[SYNC_STAGES-1];
  assign csn_fall = csn_prev_q & ~csn_s;
  assign csn_rise = ~csn_prev_q & csn_s;
  assign sck_rise = sck_s & ~sck_prev_q & ~csn_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~csn_s;

  state_e      state_q, cur_state;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  addr_byte_q, id_idx_q;
  logic [7:0]  rx_q, rx_d, tx_q, cmd_q, rd_byte;
  logic [23:0] addr_q, addr_d;
  logic        cmd_valid_q, pp_wrote_q, so_q, so_oe_q, active_q, wel_q;
  logic        byte_end, mem_we;
  logic [AW-1:0] rd_addr;
  logic [7:0]  mem_q [MEM_BYTES];

  always_comb begin
    // A CSn fall is folded into CMD so an SCK rise in the same cycle counts as opcode bit 7.
    cur_state = (state_q == S_IDLE && csn_fall) ? S_CMD : state_q;
    rx_d      = {rx_q[6:0], si_s};
    addr_d    = {addr_q[22:0], si_s};
    byte_end  = sck_rise && (bit_cnt_q == 3'd7);
    rd_addr   = (state_q == S_ADDR) ? addr_d[AW-1:0] : addr_q[AW-1:0];
    mem_we    = !rst && (state_q == S_WDATA) && byte_end;
  end

  assign rd_byte = mem_q[rd_addr];

  // NOTE: the backing store has no reset so it maps onto plain RAM and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q[AW-1:0]] <= rx_d;
  end

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      addr_byte_q <= '0;
      id_idx_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      pp_wrote_q  <= 1'b0;
      so_q        <= 1'b0;
      so_oe_q     <= 1'b0;
      active_q    <= 1'b0;
      wel_q       <= 1'b0;
    end else if (csn_rise) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      so_q        <= 1'b0;
      so_oe_q     <= 1'b0;
      active_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      pp_wrote_q  <= 1'b0;
      if (pp_wrote_q)                             wel_q <= 1'b0;
      else if (cmd_valid_q && cmd_q == OP_WREN)   wel_q <= 1'b1;
      else if (cmd_valid_q && cmd_q == OP_WRDI)   wel_q <= 1'b0;
    end else begin
      state_q <= cur_state;
      if (sck_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        rx_q      <= rx_d;
      end
      if (sck_fall && state_q == S_RDATA) begin
        so_q    <= tx_q[7];
        tx_q    <= {tx_q[6:0], 1'b0};
        so_oe_q <= 1'b1;
      end
      case (cur_state)
        S_CMD: if (byte_end) begin
          cmd_q       <= rx_d;
          cmd_valid_q <= 1'b1;
          addr_byte_q <= '0;
          state_q     <= S_IGNORE;
          case (rx_d)
            OP_READ: begin state_q <= S_ADDR; active_q <= 1'b1; end
`ifdef SPI_RESP_FAST_READ_EN
            OP_FAST: begin state_q <= S_ADDR; active_q <= 1'b1; end
`endif
            OP_PP: if (wel_q) begin state_q <= S_ADDR; active_q <= 1'b1; end
            OP_RDID: begin
              state_q  <= S_RDATA;
              tx_q     <= id_byte(2'd0);
              id_idx_q <= 2'd1;
              active_q <= 1'b1;
            end
            OP_RDSR: begin
              state_q  <= S_RDATA;
              tx_q     <= {6'b0, wel_q, 1'b0};
              active_q <= 1'b1;
            end
            default: ;
          endcase
        end
        S_ADDR: begin
          if (sck_rise) addr_q <= addr_d;
          if (byte_end) begin
            if (addr_byte_q == 2'd2) begin
`ifdef SPI_RESP_FAST_READ_EN
              if (cmd_q == OP_FAST) state_q <= S_DUMMY;
              else
`endif
              if (cmd_q == OP_PP) state_q <= S_WDATA;
              else begin
                state_q <= S_RDATA;
                tx_q    <= rd_byte;
                addr_q  <= addr_d + 24'd1;
              end
            end else begin
              addr_byte_q <= addr_byte_q + 2'd1;
            end
          end
        end
`ifdef SPI_RESP_FAST_READ_EN
        S_DUMMY: if (byte_end) begin
          state_q <= S_RDATA;
          tx_q    <= rd_byte;
          addr_q  <= addr_q + 24'd1;
        end
`endif
        S_RDATA: if (byte_end) begin
          if (cmd_q == OP_RDID) begin
            tx_q     <= id_byte(id_idx_q);
            id_idx_q <= (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
          end else if (cmd_q == OP_RDSR) begin
            tx_q <= {6'b0, wel_q, 1'b0};
          end else begin
            tx_q   <= rd_byte;
            addr_q <= addr_q + 24'd1;
          end
        end
        // Page programming wraps inside the 256-byte page.
        S_WDATA: if (byte_end) begin
          addr_q     <= {addr_q[23:8], addr_q[7:0] + 8'd1};
          pp_wrote_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign spi_so    = so_q;
  assign spi_so_oe = so_oe_q;
  assign active    = active_q;
  assign wel       = wel_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-level SPI master plus a transaction-level flash model.
`timescale 1ns/1ps
module tb_spi_flash_responder;
  localparam int          MEM_BYTES   = 4096;
  localparam logic [23:0] JEDEC_ID    = 24'h012018;
  localparam int          SYNC_STAGES = 2;
  localparam int          HALF        = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b0, spi_csn = 1'b1, spi_si = 1'b0;
  logic spi_so, spi_so_oe, active, wel;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .MEM_BYTES(MEM_BYTES), .JEDEC_ID(JEDEC_ID), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_si(spi_si),
    .spi_so(spi_so), .spi_so_oe(spi_so_oe), .active(active), .wel(wel)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash model state
  logic [7:0] mem_m   [MEM_BYTES];
  bit         known_m [MEM_BYTES];
  logic       wel_m = 1'b0;

  // Transaction buffers
  logic [7:0] tx_bytes[$], rx_bytes[$], exp_data[$];
  int         oe_cnt[$];
  bit         exp_known[$], exp_oe[$];
  int         exp_act;
  logic       new_wel;

  // Idle compare: once CSn has been high long enough, outputs must be quiet and wel must match.
  int csn_hi_cnt = 0;
  always @(posedge clk) csn_hi_cnt <= (!spi_csn || rst) ? 0 : (csn_hi_cnt < 1000 ? csn_hi_cnt + 1 : csn_hi_cnt);
  always @(negedge clk) begin
    if (!rst && csn_hi_cnt >= SYNC_STAGES + 3)
      check("idle", {28'd0, spi_so_oe, active, spi_so, wel}, {31'd0, wel_m});
  end

  function automatic logic [7:0] jedec_byte(input int k);
    return 8'((JEDEC_ID >> (8 * (2 - (k % 3)))) & 24'hFF);
  endfunction

  task automatic model_expect(input int last_bits, input bit rst_abort);
    int n, ncomp, a, m;
    logic [7:0] op;
    logic [23:0] a24;
    bit wrote;
    n = tx_bytes.size();
    ncomp = (last_bits == 8) ? n : n - 1;
    op = tx_bytes[0];
    wrote = 0;
    a = 0;
    exp_data = {}; exp_known = {}; exp_oe = {};
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(8'h00); exp_known.push_back(1'b0); exp_oe.push_back(1'b0);
    end
    new_wel = wel_m;
    exp_act = 0;
    if (ncomp >= 4) begin
      a24 = {tx_bytes[1], tx_bytes[2], tx_bytes[3]};
      a = int'(a24) % MEM_BYTES;
    end
    if (ncomp >= 1) begin
      case (op)
        8'h03: begin
          exp_act = 1;
          if (ncomp >= 4)
            for (int i = 4; i < n; i++) begin
              m = (a + i - 4) % MEM_BYTES;
              exp_oe[i] = 1; exp_data[i] = mem_m[m]; exp_known[i] = known_m[m];
            end
        end
        8'h0B: begin
`ifdef SPI_RESP_FAST_READ_EN
          exp_act = 1;
          if (ncomp >= 5)
            for (int i = 5; i < n; i++) begin
              m = (a + i - 5) % MEM_BYTES;
              exp_oe[i] = 1; exp_data[i] = mem_m[m]; exp_known[i] = known_m[m];
            end
`else
          exp_act = 0;
`endif
        end
        8'h9F: begin
          exp_act = 1;
          for (int i = 1; i < n; i++) begin
            exp_oe[i] = 1; exp_data[i] = jedec_byte(i - 1); exp_known[i] = 1;
          end
        end
        8'h05: begin
          exp_act = 1;
          for (int i = 1; i < n; i++) begin
            exp_oe[i] = 1; exp_data[i] = {6'b0, wel_m, 1'b0}; exp_known[i] = 1;
          end
        end
        8'h02: begin
          exp_act = wel_m ? 1 : 0;
          if (wel_m && ncomp >= 4)
            for (int i = 4; i < ncomp; i++) begin
              m = (a - (a % 256)) + ((a % 256 + i - 4) % 256);
              mem_m[m] = tx_bytes[i]; known_m[m] = 1; wrote = 1;
            end
        end
        8'h06: begin exp_act = -1; new_wel = 1'b1; end
        8'h04: begin exp_act = -1; new_wel = 1'b0; end
        default: exp_act = 0;
      endcase
    end
    if (wrote || rst_abort) new_wel = 1'b0;
  endtask

  task automatic txn(input int last_bits = 8, input bit sim_edge = 0, input bit rst_abort = 0);
    int n, nb, oc;
    logic [7:0] r, cur;
    n = tx_bytes.size();
    model_expect(last_bits, rst_abort);
    rx_bytes = {}; oe_cnt = {};
    if (!sim_edge) begin
      spi_csn = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1) ? last_bits : 8;
      r = '0; oc = 0; cur = tx_bytes[i];
      for (int b = 0; b < nb; b++) begin
        spi_si = cur[7-b];
        repeat (HALF) @(negedge clk);
        if (sim_edge && i == 0 && b == 0) spi_csn = 1'b0;
        r = {r[6:0], spi_so};
        oc += int'(spi_so_oe);
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
      end
      rx_bytes.push_back(r); oe_cnt.push_back(oc);
    end
    repeat (HALF) @(negedge clk);
    if (exp_act >= 0) check($sformatf("active op %0h", tx_bytes[0]), {31'd0, active}, exp_act);
    if (rst_abort) begin
      rst = 1'b1; spi_csn = 1'b1; wel_m = new_wel;
      repeat (4) @(negedge clk);
      rst = 1'b0;
    end else begin
      spi_csn = 1'b1; wel_m = new_wel;
    end
    repeat (3 * HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1) ? last_bits : 8;
      check($sformatf("oe op %0h byte %0d", tx_bytes[0], i), oe_cnt[i], exp_oe[i] ? nb : 0);
      if (nb == 8 && exp_oe[i] && exp_known[i])
        check($sformatf("so op %0h byte %0d", tx_bytes[0], i), {24'd0, rx_bytes[i]}, {24'd0, exp_data[i]});
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset outputs", {28'd0, spi_so, spi_so_oe, active, wel}, 32'd0);

    tx_bytes = {8'h9F, 8'h00, 8'h00, 8'h00}; txn();
    check("rdid b0", rx_bytes[1], 8'h01);
    check("rdid b1", rx_bytes[2], 8'h20);
    check("rdid b2", rx_bytes[3], 8'h18);

    tx_bytes = {8'h05, 8'h00}; txn();
    check("rdsr reset", rx_bytes[1], 8'h00);
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h05, 8'h00, 8'h00}; txn();
    check("rdsr wren", rx_bytes[1], 8'h02);
    check("rdsr wren rep", rx_bytes[2], 8'h02);

    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'h55}; txn();
    tx_bytes = {8'h05, 8'h00}; txn();
    check("rdsr after pp", rx_bytes[1], 8'h00);
    tx_bytes = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00}; txn();
    check("read 010", rx_bytes[4], 8'hAA);
    check("read 011", rx_bytes[5], 8'h55);

    // PP without WREN must not write
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h20, 8'h77}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h20, 8'h11}; txn();
    tx_bytes = {8'h03, 8'h00, 8'h00, 8'h20, 8'h00}; txn();
    check("pp no wren", rx_bytes[4], 8'h77);
    check("wel stays 0", {31'd0, wel}, 32'd0);

    // Page wrap on write, array wrap on read, upper address bits ignored
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'hC3}; txn();
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h0F, 8'hFF, 8'h5A}; txn();
    tx_bytes = {8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00}; txn();
    check("read fff", rx_bytes[4], 8'h5A);
    check("read wrap 000", rx_bytes[5], 8'hC3);
    tx_bytes = {8'h03, 8'h00, 8'h00, 8'hFF, 8'h00}; txn();
    check("read 0ff", rx_bytes[4], 8'h3C);
    tx_bytes = {8'h03, 8'hFF, 8'hF0, 8'h10, 8'h00}; txn();
    check("read high addr", rx_bytes[4], 8'hAA);

    // Abort mid-byte of a PP
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00}; txn();
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h30, 8'hA1, 8'hB2}; txn(4);
    tx_bytes = {8'h03, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00}; txn();
    check("abort first", rx_bytes[4], 8'hA1);
    check("abort partial", rx_bytes[5], 8'h00);
    tx_bytes = {8'h05, 8'h00}; txn();
    check("rdsr after abort", rx_bytes[1], 8'h00);

    // Partial WREN/WRDI have no effect
    tx_bytes = {8'h06}; txn(4);
    check("partial wren", {31'd0, wel}, 32'd0);
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h04}; txn(4);
    tx_bytes = {8'h05, 8'h00}; txn();
    check("partial wrdi", rx_bytes[1], 8'h02);
    tx_bytes = {8'h04}; txn();
    check("wrdi", {31'd0, wel}, 32'd0);

    tx_bytes = {8'hAB, 8'h00, 8'h00}; txn();
    tx_bytes = {8'h9F, 8'h00, 8'h00, 8'h00}; txn(8, 1);
    check("simul edge rdid", rx_bytes[1], 8'h01);
    tx_bytes = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; txn();
    check("rdid repeat", rx_bytes[4], 8'h01);

    tx_bytes = {8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00}; txn();
`ifdef SPI_RESP_FAST_READ_EN
    check("fast read", rx_bytes[5], 8'hAA);
`else
    check("fast read off", oe_cnt[5], 0);
`endif

    // Reset mid-transfer keeps written bytes and clears wel
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h02, 8'h00, 8'h00, 8'h40, 8'h5E, 8'hF0}; txn(4, 0, 1);
    tx_bytes = {8'h03, 8'h00, 8'h00, 8'h40, 8'h00}; txn();
    check("rst retains", rx_bytes[4], 8'h5E);
    tx_bytes = {8'h06}; txn();
    tx_bytes = {8'h9F, 8'h00}; txn(3, 0, 1);
    check("rst clears wel", {31'd0, wel}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
